// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_TX,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
  } ps2_state_e;

  localparam logic [7:0]  PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0]  PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0]  PS2_RESP_ACK     = 8'hFA;
  localparam int unsigned PS2_FRAME_BITS   = 10;

  function automatic int unsigned ps2_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a PS/2 pad level with a one-cycle falling-edge strobe.
module ps2_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Lines idle high, so reset to 1 to avoid a spurious strobe after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: clock inhibit, request, device-clocked frame, ACK check, timeout.
import ps2_pkg::*;

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 1200,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] send_data,
  input  logic       send_valid,
  output logic       send_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_MAX = ps2_max(INHIBIT_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  typedef logic [CNT_W-1:0] cnt_t;

  ps2_state_e state;
  logic [9:0] frame;
  logic [3:0] bit_cnt;
  cnt_t       cnt;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clock (clock),
    .reset (reset),
    .raw   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clock (clock),
    .reset (reset),
    .raw   (ps2_data_in),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  wire timed_out = (cnt == cnt_t'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      send_ready  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (send_valid && send_ready) begin
            frame       <= {1'b1, ~^send_data, send_data};
            bit_cnt     <= '0;
            cnt         <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            send_ready  <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (cnt == cnt_t'(INHIBIT_CYCLES - 1)) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b1;
            state       <= ST_REQUEST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_REQUEST: begin
          ps2_clk_oe <= 1'b0;
          state      <= ST_TX;
        end

        // The start bit is already on the line, so the first fall presents bit 0.
        ST_TX: begin
          if (clk_fall) begin
            cnt         <= '0;
            ps2_data_oe <= ~frame[bit_cnt];
            bit_cnt     <= bit_cnt + 1'b1;
            if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) state <= ST_ACK;
          end else if (timed_out) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            error       <= 1'b1;
            state       <= ST_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_ACK: begin
          if (clk_fall) begin
            cnt <= '0;
            if (!data_level) begin
              state <= ST_WAIT_IDLE;
            end else begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b0;
              error       <= 1'b1;
              state       <= ST_ERR;
            end
          end else if (timed_out) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            error       <= 1'b1;
            state       <= ST_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_level && data_level) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (clk_fall) begin
            cnt <= '0;
          end else if (timed_out) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            error       <= 1'b1;
            state       <= ST_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE, ST_ERR: begin
          send_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard, complementing the existing keyboard receive path. It sits beside the PS/2 receiver in the top level. The top level turns its open-collector enables into tri-state drives on `ps2_clock`/`ps2_data`. It runs a framed, clock-inhibit-initiated transfer paced by the device clock, checks the device ACK and guards against a silent device with a timeout.

## Interface
- `INHIBIT_CYCLES`, default 1200: cycles `ps2_clock` is held low before the request (120 µs at the 10 MHz system clock).
- `TIMEOUT_CYCLES`, default 20000: maximum cycles between device falling edges before the transfer aborts (2 ms).
- `clock`  in  1  system clock (10 MHz PLL output); single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `send_data`  in  8  byte to transmit.
- `send_valid`  in  1  request; accepted when `send_valid && send_ready` on a rising edge.
- `send_ready`  out  1  high only in IDLE.
- `ps2_clk_in`, `ps2_data_in`  in  1  raw pad levels (asynchronous).
- `ps2_clk_oe`, `ps2_data_oe`  out  1  1 = pull the line low; 0 = release the line (high-Z).
- `busy`  out  1  high from accept until return to IDLE; the top level gates `ps2_key_pressed` with it.
- `done`  out  1  one-cycle pulse on ACKed completion.
- `error`  out  1  one-cycle pulse on timeout or NACK.

## Operation
- Input conditioning: `ps2_clk_in` and `ps2_data_in` each pass through a 2-FF synchronizer. `fall` is a one-cycle strobe when the synced clock goes 1→0.
- Accept: the block latches `frame[9:0] = {1'b1, ~^send_data, send_data}`, i.e. stop bit, odd parity, data LSB-first. It clears `bit_cnt` and the timer.
- Reset values: state IDLE; `ps2_clk_oe = ps2_data_oe = 0`; `send_ready = 1`; `busy = done = error = 0`.
- States and transitions:
  - IDLE: both lines released. On accept → INHIBIT.
  - INHIBIT: `ps2_clk_oe = 1`, `ps2_data_oe = 0` for exactly INHIBIT_CYCLES cycles → REQUEST.
  - REQUEST: `ps2_clk_oe = 1`, `ps2_data_oe = 1` (start bit) for one cycle → TX.
  - TX: `ps2_clk_oe = 0`; `ps2_data_oe` holds its value.
    - On each `fall`: `ps2_data_oe = ~frame[bit_cnt]`, then `bit_cnt++`.
    - The first `fall` occurs while the start bit is already presented, and drives bit 0.
    - After the 10th `fall` the stop bit has been driven (line released) → ACK.
  - ACK: on the next `fall`, sample synced data. If 0 → WAIT_IDLE; if 1 → ERR.
  - WAIT_IDLE: wait until synced clock and synced data are both 1 → DONE.
  - DONE: `done = 1` for one cycle → IDLE.
  - ERR: `error = 1` for one cycle; both enables 0 → IDLE.
- Timeout: in TX, ACK and WAIT_IDLE a timer counts every cycle and is cleared on `fall`. Reaching TIMEOUT_CYCLES → ERR.
- The timer and the inhibit counter share one counter, sized by $clog2 of the larger parameter.
- `send_valid` while not ready is ignored; the request is not queued.
- `reset` mid-transfer: both enables are 0 on the next cycle, state IDLE, no `done`/`error` pulse.

## Timing
- Accept to `ps2_clk_oe` high: 1 cycle (INHIBIT is entered on the accept edge).
- `ps2_clk_oe` high for INHIBIT_CYCLES+1 cycles; `ps2_data_oe` rises on the last of these cycles.
- Each data, parity and stop change appears 3 cycles after the raw pad falling edge: 2 synchronizer stages plus 1 register stage.
- `done`/`error` are never asserted together. `busy` falls in the same cycle as `done`/`error` deassert, when the block returns to IDLE.
- Minimum back-to-back spacing: 1 idle cycle with `send_ready = 1` between transfers.

## Structure
- `ps2_pkg` holds:
  - the state enum;
  - command constants `PS2_CMD_SET_LEDS = 8'hED`, `PS2_CMD_RESET = 8'hFF`, `PS2_RESP_ACK = 8'hFA`;
  - `PS2_FRAME_BITS = 10`.
- Sub-module `ps2_sync_edge`: 2-FF synchronizer plus falling-edge strobe. It is instantiated twice, once for clock and once for data; the data instance ignores its strobe. The PS/2 receiver reuses it.
- The state machine, shift/index logic and counter live in `ps2_host_tx`.

## Test plan
- Send 0xED; the device model clocks at ~12 kHz and ACKs.
  - Observed bits: start 0, then 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - Required: `done` pulses once, `error` stays 0.
- Send 0x00: parity bit = 1. Send 0x01: parity bit = 0. Both complete with `done`.
- Device gives 11 clocks but leaves data high on the ACK clock → `error` pulses, both enables 0, IDLE.
- Device stops clocking after 4 bits → `error` after exactly TIMEOUT_CYCLES cycles from the last `fall`; `send_ready` returns to 1.
- `reset` during TX bit 5 → enables 0 on the next cycle, no pulses. A following send of 0xFF completes normally.
- `send_valid` held high through a transfer → exactly one accept per IDLE visit. `ps2_clk_oe` high for 1201 cycles with INHIBIT_CYCLES = 1200.
